game_tick_scheduler: RTL and testbench

//  Parametrised game-speed generator. Emits a one-cycle game_tik pulse every N rising edges of frame_tik,
//  so snake moves only land in the VGA vertical front porch. N comes from a speed level plus an automatic

---
 rtl/game_tick_scheduler_if.sv | 25 ++
 rtl/game_tick_scheduler.sv | 121 ++++++++++++
 tb/tb_game_tick_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_tick_scheduler_if.sv
// Control/status bundle between the game controller, the tick scheduler and the snake FSM.
// The controller (master) drives the run/speed controls; the scheduler (slave) returns the move strobe and status.
interface game_tick_scheduler_if #(
    parameter int unsigned LEVEL_W = 2,
    parameter int unsigned CNT_W   = 6
);
    logic               i_start;
    logic               i_pause;
    logic               i_frame_tik;
    logic [LEVEL_W-1:0] i_level;
    logic               i_apple_eaten;
    logic               o_game_tik;
    logic [CNT_W-1:0]   o_cur_period;
    logic [3:0]         o_boost;

    modport master (
        output i_start, i_pause, i_frame_tik, i_level, i_apple_eaten,
        input  o_game_tik, o_cur_period, o_boost
    );

    modport slave (
        input  i_start, i_pause, i_frame_tik, i_level, i_apple_eaten,
        output o_game_tik, o_cur_period, o_boost
    );
endinterface

// File: rtl/game_tick_scheduler.sv
// Game-speed generator: one-cycle move strobe every N frame edges, where N follows the speed level
// and an apple-driven boost, floored at MIN_PERIOD. Moves therefore only land in the frame blanking window.
module game_tick_scheduler #(
    parameter int unsigned LEVEL_W       = 2,
    parameter int unsigned NUM_LEVELS    = 4,
    parameter int unsigned CNT_W         = 6,
    parameter int unsigned BASE_PERIOD   = 4,
    parameter int unsigned LEVEL_STEP    = 1,
    parameter int unsigned MIN_PERIOD    = 1,
    parameter int unsigned SPEEDUP_EVERY = 4,
    parameter int unsigned MAX_BOOST     = 15
) (
    input  logic                 clock_25,
    input  logic                 reset,
    game_tick_scheduler_if.slave io_bus
);
    localparam int unsigned EFF_W   = CNT_W + 2;
    localparam int unsigned BOOST_W = 4;
    localparam int unsigned APPLE_W = (SPEEDUP_EVERY > 1) ? $clog2(SPEEDUP_EVERY + 1) : 1;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [BOOST_W-1:0] BOOST_SAT = BOOST_W'(MAX_BOOST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_COUNT = 2'd2,
        S_TICK  = 2'd3
    } state_t;

    state_t                   r_state;
    logic                     r_frame_q;
    logic [CNT_W-1:0]         r_frame_cnt;
    logic [CNT_W-1:0]         r_cur_period;
    logic [BOOST_W-1:0]       r_boost;
    logic [APPLE_W-1:0]       r_apple_cnt;
    logic                     r_game_tik;

    logic                     w_frame_rise;
    logic [LEVEL_W-1:0]       w_level;
    logic signed [EFF_W-1:0]  w_eff_raw;
    logic [CNT_W-1:0]         w_eff;
    logic                     w_apple_wrap;

    assign w_frame_rise = io_bus.i_frame_tik & ~r_frame_q;
    assign w_level      = (io_bus.i_level > LEVEL_MAX) ? LEVEL_MAX : io_bus.i_level;

    // Signed with two guard bits so a large level/boost goes negative instead of wrapping.
    assign w_eff_raw = $signed(EFF_W'(BASE_PERIOD))
                     - $signed(EFF_W'(w_level)) * $signed(EFF_W'(LEVEL_STEP))
                     - $signed(EFF_W'(r_boost));
    assign w_eff     = (w_eff_raw < $signed(EFF_W'(MIN_PERIOD))) ? CNT_W'(MIN_PERIOD)
                                                                 : CNT_W'(w_eff_raw);

    assign w_apple_wrap = (SPEEDUP_EVERY != 0) &&
                          ((32'(r_apple_cnt) + 32'd1) == 32'(SPEEDUP_EVERY));

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_frame_q    <= 1'b0;
            r_frame_cnt  <= '0;
            r_cur_period <= '0;
            r_boost      <= '0;
            r_apple_cnt  <= '0;
            r_game_tik   <= 1'b0;
        end else begin
            r_frame_q  <= io_bus.i_frame_tik;
            r_game_tik <= 1'b0;
            if (!io_bus.i_start) begin
                r_state      <= S_IDLE;
                r_frame_cnt  <= '0;
                r_cur_period <= '0;
                r_boost      <= '0;
                r_apple_cnt  <= '0;
            end else begin
                // Apples accrue in any running state, paused or not; the new boost waits for LOAD.
                if ((SPEEDUP_EVERY != 0) && (r_state != S_IDLE) && io_bus.i_apple_eaten) begin
                    if (w_apple_wrap) begin
                        r_apple_cnt <= '0;
                        if (r_boost < BOOST_SAT) begin
                            r_boost <= r_boost + BOOST_W'(1);
                        end
                    end else begin
                        r_apple_cnt <= r_apple_cnt + APPLE_W'(1);
                    end
                end

                case (r_state)
                    S_IDLE: begin
                        r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        r_cur_period <= w_eff;
                        r_frame_cnt  <= '0;
                        r_state      <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (w_frame_rise && !io_bus.i_pause) begin
                            if ((r_frame_cnt + CNT_W'(1)) == r_cur_period) begin
                                r_state    <= S_TICK;
                                r_game_tik <= 1'b1;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                            end
                        end
                    end
                    S_TICK: begin
                        r_state <= S_LOAD;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign io_bus.o_game_tik   = r_game_tik;
    assign io_bus.o_cur_period = r_cur_period;
    assign io_bus.o_boost      = r_boost;
endmodule

// File: tb/tb_game_tick_scheduler.sv
// Bench for game_tick_scheduler: directed vector table, multi-cycle corner sequences and a
// randomized run checked every cycle against a frames-remaining / apples-total reference model.
module tb_game_tick_scheduler;
    localparam int BASE  = 4;
    localparam int STEP  = 1;
    localparam int MINP  = 1;
    localparam int SE    = 4;
    localparam int MAXB  = 15;
    localparam int NLEV  = 4;

    logic clock_25;
    logic reset;
    int   total;
    int   bad;

    game_tick_scheduler_if #(.LEVEL_W(2), .CNT_W(6)) bus0 ();
    game_tick_scheduler_if #(.LEVEL_W(2), .CNT_W(6)) bus1 ();

    game_tick_scheduler u_dut0 (.clock_25(clock_25), .reset(reset), .io_bus(bus0));
    game_tick_scheduler #(.NUM_LEVELS(3)) u_dut1 (.clock_25(clock_25), .reset(reset), .io_bus(bus1));

    assign bus1.i_start       = bus0.i_start;
    assign bus1.i_pause       = bus0.i_pause;
    assign bus1.i_frame_tik   = bus0.i_frame_tik;
    assign bus1.i_level       = bus0.i_level;
    assign bus1.i_apple_eaten = bus0.i_apple_eaten;

    initial clock_25 = 1'b0;
    always #20 clock_25 = ~clock_25;

    // Reference model: running flag, load pending, frames remaining until the move, total apples.
    bit m_run, m_load, m_tick, m_fq;
    int m_rem, m_period, m_apples, m_boost;

    function automatic int eff_period(int lv, int b);
        int l, e;
        l = (lv > NLEV - 1) ? NLEV - 1 : lv;
        e = BASE - l * STEP - b;
        return (e < MINP) ? MINP : e;
    endfunction

    task automatic model_reset();
        m_run = 0; m_load = 0; m_tick = 0; m_fq = 0;
        m_rem = 0; m_period = 0; m_apples = 0; m_boost = 0;
    endtask

    task automatic model_step();
        bit rise;
        int old_boost;
        rise = bus0.i_frame_tik && !m_fq;
        m_fq = bus0.i_frame_tik;
        if (!bus0.i_start) begin
            m_run = 0; m_load = 0; m_tick = 0;
            m_rem = 0; m_period = 0; m_apples = 0; m_boost = 0;
        end else begin
            old_boost = m_boost;
            if (m_run && bus0.i_apple_eaten) begin
                m_apples++;
                m_boost = (m_apples / SE > MAXB) ? MAXB : m_apples / SE;
            end
            if (!m_run) begin
                m_run = 1; m_load = 1; m_tick = 0;
            end else if (m_load) begin
                m_period = eff_period(int'(bus0.i_level), old_boost);
                m_rem = m_period; m_load = 0;
            end else if (m_tick) begin
                m_tick = 0; m_load = 1;
            end else if (rise && !bus0.i_pause) begin
                m_rem--;
                if (m_rem == 0) m_tick = 1;
            end
        end
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on pre-edge inputs, then compare just after the edge.
    task automatic tick_clk();
        if (!reset) model_reset(); else model_step();
        @(posedge clock_25);
        #1;
        chk("model_tik", int'(bus0.o_game_tik), int'(m_tick));
        chk("model_period", int'(bus0.o_cur_period), m_period);
        chk("model_boost", int'(bus0.o_boost), m_boost);
    endtask

    task automatic pulse_frames(int n, output int ticks);
        ticks = 0;
        for (int i = 0; i < n; i++) begin
            bus0.i_frame_tik = 1'b1; tick_clk(); ticks += int'(bus0.o_game_tik);
            bus0.i_frame_tik = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick_clk(); ticks += int'(bus0.o_game_tik);
            end
        end
    endtask

    task automatic feed_apples(int n);
        for (int i = 0; i < n; i++) begin
            bus0.i_apple_eaten = 1'b1; tick_clk();
            bus0.i_apple_eaten = 1'b0; tick_clk();
        end
    endtask

    task automatic run_until_tick(int max_pulses);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_pulses && !seen; i++) begin
            bus0.i_frame_tik = 1'b1; tick_clk();
            if (bus0.o_game_tik) seen = 1;
            bus0.i_frame_tik = 1'b0;
            if (!seen) begin tick_clk(); tick_clk(); end
        end
        chk("tick_within_bound", int'(seen), 1);
    endtask

    task automatic restart(int lv);
        bus0.i_start = 1'b0; tick_clk();
        bus0.i_start = 1'b1; bus0.i_level = 2'(lv);
        tick_clk(); tick_clk();
    endtask

    typedef struct {
        bit s, p, f, a;
        int lv;
        int tik, per, bst;
    } vec_t;

    vec_t tab[17];

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int cnt;
        total = 0; bad = 0;

        tab[0]  = '{0,0,0,0,0, 0,0,0};
        tab[1]  = '{1,0,0,0,3, 0,0,0};
        tab[2]  = '{1,0,0,0,3, 0,1,0};
        tab[3]  = '{1,0,1,0,3, 1,1,0};
        tab[4]  = '{1,0,1,0,3, 0,1,0};
        tab[5]  = '{1,0,1,0,2, 0,2,0};
        tab[6]  = '{1,0,1,0,2, 0,2,0};
        tab[7]  = '{1,0,0,0,2, 0,2,0};
        tab[8]  = '{1,0,1,0,2, 0,2,0};
        tab[9]  = '{1,0,0,1,2, 0,2,0};
        tab[10] = '{1,1,1,0,2, 0,2,0};
        tab[11] = '{1,0,0,0,2, 0,2,0};
        tab[12] = '{1,0,1,1,2, 1,2,0};
        tab[13] = '{1,0,0,1,0, 0,2,0};
        tab[14] = '{1,0,0,1,0, 0,4,1};
        tab[15] = '{0,0,0,0,0, 0,0,0};
        tab[16] = '{0,0,0,0,0, 0,0,0};

        reset = 1'b0;
        bus0.i_start = 1'b0; bus0.i_pause = 1'b0; bus0.i_frame_tik = 1'b0;
        bus0.i_level = 2'd0; bus0.i_apple_eaten = 1'b0;
        model_reset();
        repeat (3) @(posedge clock_25);
        #1;
        chk("reset_tik", int'(bus0.o_game_tik), 0);
        chk("reset_period", int'(bus0.o_cur_period), 0);
        chk("reset_boost", int'(bus0.o_boost), 0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            bus0.i_start = tab[i].s; bus0.i_pause = tab[i].p;
            bus0.i_frame_tik = tab[i].f; bus0.i_apple_eaten = tab[i].a;
            bus0.i_level = 2'(tab[i].lv);
            tick_clk();
            chk($sformatf("vec%0d_tik", i), int'(bus0.o_game_tik), tab[i].tik);
            chk($sformatf("vec%0d_period", i), int'(bus0.o_cur_period), tab[i].per);
            chk($sformatf("vec%0d_boost", i), int'(bus0.o_boost), tab[i].bst);
        end
        bus0.i_pause = 1'b0; bus0.i_frame_tik = 1'b0; bus0.i_apple_eaten = 1'b0;

        // Level clamping: level 3 on a 3-level instance behaves like level 2.
        bus0.i_start = 1'b1; bus0.i_level = 2'd3;
        tick_clk(); tick_clk();
        chk("clamp_4lv_period", int'(bus0.o_cur_period), 1);
        chk("clamp_3lv_period", int'(bus1.o_cur_period), 2);

        // Pause freezes the count; the tick comes two rises after release.
        restart(0);
        chk("pause_base_period", int'(bus0.o_cur_period), 4);
        pulse_frames(2, t);      chk("pause_pre_ticks", t, 0);
        bus0.i_pause = 1'b1;
        pulse_frames(5, t);      chk("pause_held_ticks", t, 0);
        bus0.i_pause = 1'b0;
        pulse_frames(1, t);      chk("pause_third_ticks", t, 0);
        bus0.i_frame_tik = 1'b1; tick_clk();
        chk("tick_latency", int'(bus0.o_game_tik), 1);
        bus0.i_frame_tik = 1'b0; tick_clk();
        chk("tick_one_cycle", int'(bus0.o_game_tik), 0);

        // A long-held frame marker counts as one edge.
        restart(3);
        cnt = 0;
        bus0.i_frame_tik = 1'b1;
        for (int i = 0; i < 200; i++) begin tick_clk(); cnt += int'(bus0.o_game_tik); end
        bus0.i_frame_tik = 1'b0;
        for (int i = 0; i < 10; i++) begin tick_clk(); cnt += int'(bus0.o_game_tik); end
        chk("held_frame_ticks", cnt, 1);

        // Apple boost, applied at the next load, floored, saturated.
        restart(0);
        feed_apples(4);
        chk("boost_after_4", int'(bus0.o_boost), 1);
        chk("period_not_mid_count", int'(bus0.o_cur_period), 4);
        run_until_tick(10);
        tick_clk(); tick_clk();
        chk("period_boost1", int'(bus0.o_cur_period), 3);
        feed_apples(12);
        chk("boost_after_16", int'(bus0.o_boost), 4);
        run_until_tick(10);
        tick_clk(); tick_clk();
        chk("period_floor", int'(bus0.o_cur_period), 1);
        feed_apples(48);
        chk("boost_saturated", int'(bus0.o_boost), 15);
        run_until_tick(10);
        tick_clk(); tick_clk();
        chk("period_floor_sat", int'(bus0.o_cur_period), 1);

        // Stop mid-count with a would-be ticking rise in the same cycle.
        bus0.i_frame_tik = 1'b1; bus0.i_start = 1'b0;
        tick_clk();
        chk("stop_tik", int'(bus0.o_game_tik), 0);
        chk("stop_period", int'(bus0.o_cur_period), 0);
        chk("stop_boost", int'(bus0.o_boost), 0);
        bus0.i_frame_tik = 1'b0;

        // Asynchronous reset while the strobe is high.
        restart(3);
        bus0.i_frame_tik = 1'b1; tick_clk();
        chk("pre_reset_tik", int'(bus0.o_game_tik), 1);
        reset = 1'b0;
        #1;
        chk("async_reset_tik", int'(bus0.o_game_tik), 0);
        chk("async_reset_period", int'(bus0.o_cur_period), 0);
        bus0.i_frame_tik = 1'b0;
        tick_clk(); tick_clk();
        reset = 1'b1;
        tick_clk();

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bus0.i_start       = ($urandom_range(0, 99) != 0);
            bus0.i_pause       = ($urandom_range(0, 7) == 0);
            bus0.i_frame_tik   = ($urandom_range(0, 2) == 0);
            bus0.i_level       = 2'($urandom_range(0, 3));
            bus0.i_apple_eaten = ($urandom_range(0, 4) == 0);
            reset              = ($urandom_range(0, 499) != 0);
            tick_clk();
        end
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
